// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: memory-access FSM states, RV32I load/store size
// codes and the access legality rule.
package pipe_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StRsp,
      StDone
   } ma_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // funct3[1:0] is the access size; loads may also use the unsigned forms.
   function automatic logic access_legal(input logic       is_load,
                                         input logic [2:0] f3,
                                         input logic [1:0] alo);
      logic align_ok;
      case (f3[1:0])
         2'b00:   align_ok = 1'b1;
         2'b01:   align_ok = ~alo[0];
         2'b10:   align_ok = (alo == 2'b00);
         default: align_ok = 1'b0;
      endcase
      return align_ok && (is_load ? (f3 != 3'b110) : ~f3[2]);
   endfunction

endpackage

// File: rtl/ld_align_ext.sv
// Selects the addressed byte/halfword of a read word and sign/zero-extends it
// to 32 bits; purely combinational so forwarding logic can share it.
module ld_align_ext
   import pipe_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] result_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = rdata_i[{addr_lo_i, 3'b000} +: 8];
      half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (funct3_i)
         F3_B:    result_o = {{24{byte_v[7]}}, byte_v};
         F3_H:    result_o = {{16{half_v[15]}}, half_v};
         F3_W:    result_o = rdata_i;
         F3_BU:   result_o = {24'h0, byte_v};
         F3_HU:   result_o = {16'h0, half_v};
         default: result_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/ma_mem_access_unit.sv
// Memory-access stage: issues one data-memory request per MA load/store, stalls
// upstream until it completes, faults on misalignment or times out.
module ma_mem_access_unit
   import pipe_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TMR_W          = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic        is_ld,
   input  logic        is_st,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] st_data,
   output logic        stall_out,
   output logic [31:0] ld_result,
   output logic        done,
   output logic        access_err,
   output logic        bus_err,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_we,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_be,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_rdata
);

   localparam bit              TmrEn   = (TIMEOUT_CYCLES != 0);
   localparam logic [TMR_W-1:0] TmrLast = TMR_W'(TIMEOUT_CYCLES - 1);

   ma_state_e        state_q, state_d;
   logic [2:0]       f3_q, f3_d;
   logic [1:0]       alo_q, alo_d;
   logic [31:0]      req_addr_q, req_addr_d;
   logic             req_we_q, req_we_d;
   logic [3:0]       req_be_q, req_be_d;
   logic [31:0]      req_wdata_q, req_wdata_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [31:0]      ld_result_q, ld_result_d;
   logic             acc_err_q, acc_err_d;
   logic             bus_err_q, bus_err_d;
   logic [31:0]      rsp_ext;

   ld_align_ext u_ld_align_ext (
      .funct3_i  (f3_q),
      .addr_lo_i (alo_q),
      .rdata_i   (mem_rsp_rdata),
      .result_o  (rsp_ext)
   );

   always_comb begin
      state_d     = state_q;
      f3_d        = f3_q;
      alo_d       = alo_q;
      req_addr_d  = req_addr_q;
      req_we_d    = req_we_q;
      req_be_d    = req_be_q;
      req_wdata_d = req_wdata_q;
      tmr_d       = tmr_q;
      ld_result_d = ld_result_q;
      acc_err_d   = acc_err_q;
      bus_err_d   = bus_err_q;
      stall_out   = 1'b0;

      case (state_q)
         StIdle: begin
            if (valid_in && (is_ld || is_st)) begin
               stall_out  = 1'b1;
               f3_d       = funct3;
               alo_d      = addr[1:0];
               req_addr_d = {addr[31:2], 2'b00};
               // A load wins when both op flags are set.
               req_we_d   = ~is_ld;
               if (is_ld) begin
                  req_be_d    = 4'b1111;
                  req_wdata_d = 32'h0;
               end else begin
                  case (funct3)
                     F3_B: begin
                        req_be_d    = 4'b0001 << addr[1:0];
                        req_wdata_d = {4{st_data[7:0]}};
                     end
                     F3_H: begin
                        req_be_d    = 4'b0011 << addr[1:0];
                        req_wdata_d = {2{st_data[15:0]}};
                     end
                     default: begin
                        req_be_d    = 4'b1111;
                        req_wdata_d = st_data;
                     end
                  endcase
               end
               if (access_legal(is_ld, funct3, addr[1:0])) begin
                  state_d = StReq;
               end else begin
                  state_d     = StDone;
                  acc_err_d   = 1'b1;
                  ld_result_d = 32'h0;
               end
            end
         end

         StReq: begin
            stall_out = 1'b1;
            if (mem_req_ready) begin
               if (req_we_q) begin
                  state_d = StDone;
               end else begin
                  state_d = StRsp;
                  tmr_d   = '0;
               end
            end
         end

         StRsp: begin
            stall_out = 1'b1;
            // A response on the last permitted cycle still beats the timeout.
            if (mem_rsp_valid) begin
               ld_result_d = rsp_ext;
               state_d     = StDone;
            end else if (TmrEn && (tmr_q == TmrLast)) begin
               ld_result_d = 32'h0;
               bus_err_d   = 1'b1;
               state_d     = StDone;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end

         StDone: begin
            acc_err_d = 1'b0;
            bus_err_d = 1'b0;
            state_d   = StIdle;
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         f3_q        <= 3'b000;
         alo_q       <= 2'b00;
         req_addr_q  <= 32'h0;
         req_we_q    <= 1'b0;
         req_be_q    <= 4'b0000;
         req_wdata_q <= 32'h0;
         tmr_q       <= '0;
         ld_result_q <= 32'h0;
         acc_err_q   <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         f3_q        <= f3_d;
         alo_q       <= alo_d;
         req_addr_q  <= req_addr_d;
         req_we_q    <= req_we_d;
         req_be_q    <= req_be_d;
         req_wdata_q <= req_wdata_d;
         tmr_q       <= tmr_d;
         ld_result_q <= ld_result_d;
         acc_err_q   <= acc_err_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign done          = (state_q == StDone);
   assign access_err    = (state_q == StDone) && acc_err_q;
   assign bus_err       = (state_q == StDone) && bus_err_q;
   assign ld_result     = ld_result_q;
   assign mem_req_valid = (state_q == StReq);
   assign mem_req_we    = req_we_q;
   assign mem_req_addr  = req_addr_q;
   assign mem_req_wdata = req_wdata_q;
   assign mem_req_be    = req_be_q;

endmodule

// File: tb/tb_ma_mem_access_unit.sv
// Randomized bench for ma_mem_access_unit: the bench plays data memory and
// predicts every access from the load/store rules with plain arithmetic.
module tb_ma_mem_access_unit;

   localparam int Tmo = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in, is_ld, is_st;
   logic [2:0]  funct3;
   logic [31:0] addr, st_data;
   logic        stall_out, done, access_err, bus_err;
   logic [31:0] ld_result;
   logic        mem_req_valid, mem_req_ready, mem_req_we;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic [3:0]  mem_req_be;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_rdata;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_ld  = 32'h0;

   ma_mem_access_unit #(
      .TIMEOUT_CYCLES (Tmo),
      .TMR_W          (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .valid_in      (valid_in),
      .is_ld         (is_ld),
      .is_st         (is_st),
      .funct3        (funct3),
      .addr          (addr),
      .st_data       (st_data),
      .stall_out     (stall_out),
      .ld_result     (ld_result),
      .done          (done),
      .access_err    (access_err),
      .bus_err       (bus_err),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_we    (mem_req_we),
      .mem_req_addr  (mem_req_addr),
      .mem_req_wdata (mem_req_wdata),
      .mem_req_be    (mem_req_be),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_rdata (mem_rsp_rdata)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected load value straight from the extension rules.
   function automatic logic [31:0] extend_model(input int f3, input logic [31:0] a,
                                                input logic [31:0] word);
      logic [31:0] b, h;
      b = (word >> (8 * (a % 4))) % 256;
      h = (word >> (16 * ((a / 2) % 2))) % 65536;
      case (f3)
         0:       return (b >= 128) ? b - 32'd256 : b;
         1:       return (h >= 32768) ? h - 32'd65536 : h;
         2:       return word;
         4:       return b;
         5:       return h;
         default: return 32'h0;
      endcase
   endfunction

   task automatic junk_bus();
      mem_req_ready = 1'($urandom);
      mem_rsp_valid = 1'($urandom);
      mem_rsp_rdata = $urandom;
   endtask

   task automatic run_op(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] word,
                         input int req_dly, input int rsp_dly);
      int          f3i, sz, exp_stall, stall_n, req_n, rsp_n;
      bit          mem_op, legal, tmo, hs, in_rsp, got_done;
      logic [31:0] exp_be, exp_wd;
      f3i    = f3;
      mem_op = ld || st;
      sz     = (f3i % 4 == 0) ? 1 : (f3i % 4 == 1) ? 2 : 4;
      legal  = mem_op && (a % sz == 0) &&
               (ld ? (f3i inside {0, 1, 2, 4, 5}) : (f3i <= 2));
      tmo    = ld && legal && (rsp_dly >= Tmo);
      exp_be = 32'hF;
      exp_wd = sd;
      if (!ld) begin
         if (f3i == 0) begin
            exp_be = 32'd1 << (a % 4);
            exp_wd = (sd % 256) * 32'h01010101;
         end else if (f3i == 1) begin
            exp_be = 32'd3 << (a % 4);
            exp_wd = (sd % 65536) * 32'h00010001;
         end
      end
      if (mem_op && !legal)  exp_ld = 32'h0;
      else if (ld && tmo)    exp_ld = 32'h0;
      else if (ld)           exp_ld = extend_model(f3i, a, word);
      if (!mem_op)     exp_stall = 0;
      else if (!legal) exp_stall = 1;
      else if (!ld)    exp_stall = 2 + req_dly;
      else if (tmo)    exp_stall = 2 + req_dly + Tmo;
      else             exp_stall = 3 + req_dly + rsp_dly;

      valid_in = 1'b1; is_ld = ld; is_st = st; funct3 = f3; addr = a; st_data = sd;
      junk_bus();
      #1;
      check_eq("stall_detect", 32'(stall_out), 32'(mem_op));
      stall_n = stall_out ? 1 : 0;
      if (!mem_op) begin
         @(posedge clk); #1;
         valid_in = 1'b0;
         check_eq("nonmem_done", 32'(done), 32'h0);
         check_eq("nonmem_req", 32'(mem_req_valid), 32'h0);
         check_eq("nonmem_ld_hold", ld_result, exp_ld);
         return;
      end

      req_n = 0; rsp_n = 0; hs = 0; in_rsp = 0; got_done = 0;
      for (int c = 0; c < 60 && !got_done; c++) begin
         @(posedge clk); #1;
         valid_in = 1'b0;
         is_ld    = 1'($urandom); is_st = 1'($urandom);
         funct3   = 3'($urandom); addr  = $urandom; st_data = $urandom;
         junk_bus();
         if (hs) in_rsp = 1;
         hs = 0;
         if (done) begin
            got_done = 1;
         end else begin
            if (stall_out) stall_n++;
            if (mem_req_valid) begin
               check_eq("req_addr", mem_req_addr, a - (a % 4));
               check_eq("req_be", 32'(mem_req_be), exp_be);
               check_eq("req_we", 32'(mem_req_we), 32'(!ld));
               if (!ld) check_eq("req_wdata", mem_req_wdata, exp_wd);
               mem_req_ready = (req_n == req_dly);
               hs            = (req_n == req_dly);
               req_n++;
            end else if (in_rsp) begin
               mem_rsp_valid = (rsp_n == rsp_dly);
               if (mem_rsp_valid) mem_rsp_rdata = word;
               rsp_n++;
            end
         end
      end
      check_eq("done_seen", 32'(got_done), 32'h1);
      check_eq("req_issued", 32'(req_n > 0), 32'(legal));
      check_eq("stall_cycles", 32'(stall_n), 32'(exp_stall));
      check_eq("done_stall", 32'(stall_out), 32'h0);
      check_eq("access_err", 32'(access_err), 32'(!legal));
      check_eq("bus_err", 32'(bus_err), 32'(tmo));
      check_eq("ld_result", ld_result, exp_ld);
      @(posedge clk); #1;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      check_eq("done_pulse", {29'h0, done, access_err, bus_err}, 32'h0);
      check_eq("ld_hold", ld_result, exp_ld);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_ctl"}, {26'h0, stall_out, done, access_err, bus_err, mem_req_valid,
                               mem_req_we}, 32'h0);
      check_eq({tag, "_ld"}, ld_result, 32'h0);
      check_eq({tag, "_addr"}, mem_req_addr, 32'h0);
      check_eq({tag, "_wdata"}, mem_req_wdata, 32'h0);
      check_eq({tag, "_be"}, 32'(mem_req_be), 32'h0);
   endtask

   task automatic reset_in_flight();
      // Async reset while a request is waiting for ready.
      valid_in = 1'b1; is_ld = 1'b1; is_st = 1'b0; funct3 = 3'b010; addr = 32'h40;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      @(posedge clk); #1;
      valid_in = 1'b0;
      check_eq("pre_rst_req", 32'(mem_req_valid), 32'h1);
      #2; rst = 1'b1; #1;
      check_all_zero("rst_req");
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      // Async reset while waiting for the read response.
      run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h13572468, 0, 0);
      valid_in = 1'b1; is_ld = 1'b1; is_st = 1'b0; funct3 = 3'b010; addr = 32'h44;
      @(posedge clk); #1;
      valid_in = 1'b0; mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      @(posedge clk); #2;
      rst = 1'b1; #1;
      check_all_zero("rst_rsp");
      @(negedge clk);
      mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hCAFEF00D;
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      exp_ld = 32'h0;
      check_all_zero("late_rsp");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; valid_in = 1'b0; is_ld = 1'b0; is_st = 1'b0; funct3 = 3'b000;
      addr = 32'h0; st_data = 32'h0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
      run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 0);
      run_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0, 0);
      run_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 5, 0);
      run_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h11111111, 0, 0);
      run_op(1'b1, 1'b0, 3'b001, 32'h302, 32'h0, 32'h8001FFFF, 1, 3);
      run_op(1'b1, 1'b0, 3'b010, 32'h080, 32'h0, 32'h12345678, 0, Tmo);
      run_op(1'b1, 1'b0, 3'b011, 32'h000, 32'h0, 32'h12345678, 0, 0);
      run_op(1'b0, 1'b1, 3'b100, 32'h000, 32'h55AA55AA, 32'h0, 0, 0);
      run_op(1'b0, 1'b1, 3'b010, 32'h402, 32'h55AA55AA, 32'h0, 0, 0);
      run_op(1'b1, 1'b1, 3'b101, 32'h006, 32'h0, 32'hF00DBEEF, 2, 1);
      run_op(1'b0, 1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 0, 0);

      for (int i = 0; i < 150; i++) begin
         logic ld_r, st_r;
         ld_r = 1'($urandom);
         st_r = ($urandom % 8 != 0) ? !ld_r : 1'($urandom);
         run_op(ld_r, st_r, 3'($urandom), $urandom, $urandom, $urandom,
                int'($urandom % 4), int'($urandom % 6));
      end

      reset_in_flight();
      run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0BADC0DE, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ma_mem_access_unit.md
Name: ma_mem_access_unit

Overview:
- Memory-access stage engine that issues loads and stores from the EX/MA boundary to the data memory over a valid/ready request and response handshake.
- Aligns and extends load data into the 32-bit value the MA/WB latch captures.
- Stalls the pipeline while an access is outstanding.
- Acts as the initiator for data memory and the producer for the MA/WB latch inputs.

Parameters:
- TIMEOUT_CYCLES, 255, maximum cycles spent in RSP before bus_err is flagged; 0 disables the timeout.
- TMR_W, 8, width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**TMR_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- valid_in  in  1  a valid instruction is present in MA
- is_ld  in  1  instruction is a load
- is_st  in  1  instruction is a store
- funct3  in  3  access size and signedness (RV32I encoding)
- addr  in  32  byte address (the ALU result)
- st_data  in  32  store data from rs2
- stall_out  out  1  hold upstream stages
- ld_result  out  32  extended load data
- done  out  1  one-cycle pulse when an access completes
- access_err  out  1  one-cycle pulse on misaligned or illegal funct3
- bus_err  out  1  one-cycle pulse on response timeout
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts the request
- mem_req_we  out  1  1 = store
- mem_req_addr  out  32  word address, {addr[31:2], 2'b00}
- mem_req_wdata  out  32  lane-replicated store data
- mem_req_be  out  4  byte enables
- mem_rsp_valid  in  1  read data valid
- mem_rsp_rdata  in  32  read word

Behaviour:
- Reset: every output is 0 and the state is IDLE. Reset takes effect immediately, including mid-transaction, so mem_req_valid drops asynchronously.
- States are IDLE, REQ, RSP and DONE.
- IDLE:
  - If valid_in and (is_ld or is_st): capture op, funct3, addr and st_data, and set stall_out=1.
  - If the captured access is legal, go to REQ. Otherwise go to DONE and pulse access_err in DONE.
  - Non-memory instructions or valid_in=0: stall_out=0 and ld_result holds its value.
- REQ:
  - mem_req_valid=1, and all request fields are registered and stable until the handshake.
  - On mem_req_ready: a store goes to DONE; a load goes to RSP and clears the timer.
- RSP:
  - Wait for mem_rsp_valid, then register the extended data into ld_result and go to DONE.
  - The timer increments each cycle. If the timer reaches TIMEOUT_CYCLES (when nonzero), pulse bus_err, set ld_result=0 and go to DONE.
- DONE:
  - stall_out=0 and done=1 for one cycle, then go to IDLE.
  - Upstream advances on this cycle, so the next instruction is sampled in IDLE on the following cycle.
- stall_out=1 in REQ and RSP, and in IDLE on the cycle a memory op is detected.
- Minimum load: 3 stall cycles plus the DONE cycle. Minimum store: 2 stall cycles plus the DONE cycle.
- Legality:
  - LW/SW need addr[1:0]=0.
  - LH/LHU/SH need addr[0]=0.
  - funct3 011, 110 and 111 are illegal for loads; funct3 values above 010 are illegal for stores.
  - An illegal access issues no memory request and sets ld_result=0.
- Stores:
  - SB: be = 4'b0001<<addr[1:0], wdata = {4{st_data[7:0]}}.
  - SH: be = 4'b0011<<addr[1:0], wdata = {2{st_data[15:0]}}.
  - SW: be = 4'b1111, wdata = st_data.
- Loads: be = 4'b1111. The byte is rdata >> (8*addr[1:0]), and the halfword is selected by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- is_ld and is_st both set: treat as a load.
- A mem_rsp_valid arriving outside RSP is ignored.
- mem_req_ready while not in REQ is ignored.

Decomposition:
- Shared package pipe_pkg holds:
  - the state enum (IDLE/REQ/RSP/DONE);
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
- One sub-module, ld_align_ext: combinational funct3 + addr[1:0] + rdata -> 32-bit result, reused by forwarding logic.

Test Plan:
- LW at addr 0x100, ready=1, rdata 0xDEADBEEF the next cycle: req_addr=0x100 and be=1111. ld_result=0xDEADBEEF with done on the 4th cycle; stall high for 3 cycles.
- LB at addr 0x103, rdata 0x80FF1234 -> ld_result=0xFFFFFF80. The same access as LBU -> 0x00000080.
- SH at addr 0x202, st_data 0x0000ABCD, ready held low for 5 cycles: mem_req_valid stays high with stable fields. be=1100, wdata=0xABCDABCD; done 1 cycle after ready.
- LW at addr 0x101 -> no mem_req_valid, access_err and done pulse together, ld_result=0.
- TIMEOUT_CYCLES=4 and no response -> bus_err after 4 cycles in RSP, ld_result=0, return to IDLE.
- rst asserted in RSP, then a late rsp_valid: all outputs 0 immediately and the late response is ignored. The next LW completes normally.
